matvec_ax: RTL and testbench

Sequential fixed-point matrix-vector multiplier directly downstream of the constant-matrix block. It consumes the flat M×N coefficient bus A and an N-element vector x, and streams y = A·x out one row at a time over a valid/ready handshake to the RLS update logic. One signed MAC is time-shared across all M·N products.

---
 rtl/matvec_ax.sv | 174 +++++++++++++++++
 tb/tb_matvec_ax.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_ax.sv
// matvec_ax: sequential fixed-point matrix-vector multiplier, y = A*x.
// A single signed MAC walks each row of A against the latched vector x.
// Each finished row is scaled, saturated and offered on a valid/ready port.
module matvec_ax #(
   parameter int nBits = 32,
   parameter int M     = 32,
   parameter int N     = 16,
   parameter int FRAC  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [M*N*nBits-1:0]   A,
   input  logic [N*nBits-1:0]     x,
   input  logic                   start,
   output logic                   busy,
   output logic [nBits-1:0]       y_data,
   output logic [$clog2(M)-1:0]   y_index,
   output logic                   y_valid,
   input  logic                   y_ready,
   output logic                   done
);

   localparam int IW  = $clog2(M);
   localparam int CW  = $clog2(N);
   localparam int AW  = 2 * nBits + CW;
   localparam int AIW = $clog2(M * N * nBits);
   localparam int XIW = $clog2(N * nBits);

   // Saturation limits expressed at accumulator width
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-nBits+1){1'b0}}, {(nBits-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-nBits+1){1'b1}}, {(nBits-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state_q,   state_d;
   logic [IW-1:0]           row_q,     row_d;
   logic [CW-1:0]           col_q,     col_d;
   logic signed [AW-1:0]    acc_q,     acc_d;
   logic [N*nBits-1:0]      x_q,       x_d;
   logic                    busy_q,    busy_d;
   logic [nBits-1:0]        y_data_q,  y_data_d;
   logic [IW-1:0]           y_index_q, y_index_d;
   logic                    y_valid_q, y_valid_d;
   logic                    done_q,    done_d;

   logic [AIW-1:0]          a_idx_s;
   logic [XIW-1:0]          x_idx_s;
   logic [nBits-1:0]        a_elem_s;
   logic [nBits-1:0]        x_elem_s;
   logic signed [2*nBits-1:0] a_ext_s;
   logic signed [2*nBits-1:0] x_ext_s;
   logic signed [2*nBits-1:0] prod_s;
   logic signed [AW-1:0]    sum_s;
   logic signed [AW-1:0]    shift_s;
   logic [nBits-1:0]        sat_s;

   // Datapath: select A(row,col) and x[col], multiply, accumulate, scale, saturate
   always_comb begin
      a_idx_s  = AIW'((32'(row_q) * 32'(N) + 32'(col_q)) * 32'(nBits));
      x_idx_s  = XIW'(32'(col_q) * 32'(nBits));
      a_elem_s = A[a_idx_s +: nBits];
      x_elem_s = x_q[x_idx_s +: nBits];
      a_ext_s  = {{nBits{a_elem_s[nBits-1]}}, a_elem_s};
      x_ext_s  = {{nBits{x_elem_s[nBits-1]}}, x_elem_s};
      // Both operands are sign-extended, so the low 2*nBits of the product are exact
      prod_s   = a_ext_s * x_ext_s;
      sum_s    = acc_q + {{CW{prod_s[2*nBits-1]}}, prod_s};
      shift_s  = sum_s >>> FRAC;
      if (shift_s > SAT_MAX) begin
         sat_s = {1'b0, {(nBits-1){1'b1}}};
      end else if (shift_s < SAT_MIN) begin
         sat_s = {1'b1, {(nBits-1){1'b0}}};
      end else begin
         sat_s = shift_s[nBits-1:0];
      end
   end

   // Next-state logic for the IDLE -> MAC -> OUT sequencer and its outputs
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      acc_d     = acc_q;
      x_d       = x_q;
      busy_d    = busy_q;
      y_data_d  = y_data_q;
      y_index_d = y_index_q;
      y_valid_d = y_valid_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x;
               row_d   = '0;
               col_d   = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
               state_d = MAC;
            end else begin
               state_d = IDLE;
            end
         end
         MAC: begin
            if (col_q == CW'(N - 1)) begin
               y_data_d  = sat_s;
               y_index_d = row_q;
               y_valid_d = 1'b1;
               acc_d     = '0;
               col_d     = '0;
               state_d   = OUT;
            end else begin
               acc_d = sum_s;
               col_d = col_q + 1'b1;
            end
         end
         OUT: begin
            if (y_ready) begin
               y_valid_d = 1'b0;
               if (row_q == IW'(M - 1)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = MAC;
               end
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         acc_q     <= '0;
         x_q       <= '0;
         busy_q    <= 1'b0;
         y_data_q  <= '0;
         y_index_q <= '0;
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         acc_q     <= acc_d;
         x_q       <= x_d;
         busy_q    <= busy_d;
         y_data_q  <= y_data_d;
         y_index_q <= y_index_d;
         y_valid_q <= y_valid_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign y_data  = y_data_q;
   assign y_index = y_index_q;
   assign y_valid = y_valid_q;
   assign done    = done_q;

endmodule

// File: tb/tb_matvec_ax.sv
// tb_matvec_ax: directed self-checking bench for matvec_ax.
module tb_matvec_ax;

   localparam int NB   = 32;
   localparam int M    = 32;
   localparam int N    = 16;
   localparam int FRAC = 16;
   localparam int IW   = $clog2(M);

   localparam logic signed [95:0] G_MAX = 96'sh7FFF_FFFF;
   localparam logic signed [95:0] G_MIN = -96'sh8000_0000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 y_ready = 1'b1;
   logic [M*N*NB-1:0]    a_bus;
   logic [N*NB-1:0]      x_bus;
   logic                 busy;
   logic [NB-1:0]        y_data;
   logic [IW-1:0]        y_index;
   logic                 y_valid;
   logic                 done;

   logic [NB-1:0] a_m [M][N];
   logic [NB-1:0] x_v [N];
   logic [NB-1:0] exp_y [M];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   matvec_ax #(.nBits(NB), .M(M), .N(N), .FRAC(FRAC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (a_bus),
      .x       (x_bus),
      .start   (start),
      .busy    (busy),
      .y_data  (y_data),
      .y_index (y_index),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      a_bus = '0;
      x_bus = '0;
      for (int r = 0; r < M; r++) begin
         for (int c = 0; c < N; c++) begin
            a_bus[(r*N+c)*NB +: NB] = a_m[r][c];
         end
      end
      for (int c = 0; c < N; c++) begin
         x_bus[c*NB +: NB] = x_v[c];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bit-accurate reference: wide signed sum, arithmetic shift, saturate
   function automatic logic [NB-1:0] golden(input int r);
      logic signed [95:0] s;
      logic signed [95:0] ae;
      logic signed [95:0] xe;
      s = '0;
      for (int c = 0; c < N; c++) begin
         ae = {{64{a_m[r][c][NB-1]}}, a_m[r][c]};
         xe = {{64{x_v[c][NB-1]}}, x_v[c]};
         s  = s + ae * xe;
      end
      s = s >>> FRAC;
      if (s > G_MAX) return 32'h7FFF_FFFF;
      else if (s < G_MIN) return 32'h8000_0000;
      else return s[NB-1:0];
   endfunction

   task automatic set_all(input logic [NB-1:0] av, input logic [NB-1:0] xv);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) a_m[r][c] = av;
      for (int c = 0; c < N; c++) x_v[c] = xv;
   endtask

   task automatic set_pattern();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            a_m[r][c] = 32'((r + 1) * 32'h0723_4567) ^ 32'(c * 32'h0011_0011);
   endtask

   // One multiply: start, collect every row, optionally stall, pulse start, or abort by reset
   task automatic do_run(input int stall_row, input int pulse_row, input int abort_row, input bit chk_time);
      int t;
      int wait_n;
      logic [NB-1:0] hold_d;
      logic [IW-1:0] hold_i;
      start = 1'b1;
      step();
      start = 1'b0;
      t = cyc;
      check_val("busy_on_start", 64'(busy), 64'd1);
      for (int r = 0; r < M; r++) begin
         wait_n = 0;
         while (!y_valid && wait_n < 64) begin
            if (r == abort_row && wait_n == 3) begin
               rst_n = 1'b0;
               step();
               check_val("abort_busy", 64'(busy), 64'd0);
               check_val("abort_y_valid", 64'(y_valid), 64'd0);
               check_val("abort_y_data", 64'(y_data), 64'd0);
               check_val("abort_done", 64'(done), 64'd0);
               rst_n = 1'b1;
               return;
            end
            step();
            wait_n++;
         end
         if (!y_valid) begin
            check_val($sformatf("y_valid_timeout_row%0d", r), 64'(y_valid), 64'd1);
            return;
         end
         if (chk_time && r == 0) check_val("first_valid_cycle", 64'(cyc), 64'(t + N));
         check_val($sformatf("y_index_row%0d", r), 64'(y_index), 64'(r));
         check_val($sformatf("y_data_row%0d", r), 64'(y_data), 64'(exp_y[r]));
         if (r == stall_row) begin
            y_ready = 1'b0;
            hold_d = y_data;
            hold_i = y_index;
            for (int k = 0; k < 5; k++) begin
               step();
               check_val("stall_y_valid", 64'(y_valid), 64'd1);
               check_val("stall_y_data", 64'(y_data), 64'(hold_d));
               check_val("stall_y_index", 64'(y_index), 64'(hold_i));
            end
            y_ready = 1'b1;
         end
         if (r == pulse_row) start = 1'b1;
         step();
         start = 1'b0;
         if (r == stall_row) check_val("after_stall_y_valid", 64'(y_valid), 64'd0);
      end
      check_val("done_pulse", 64'(done), 64'd1);
      check_val("busy_end", 64'(busy), 64'd0);
      if (chk_time) check_val("done_cycle", 64'(cyc), 64'(t + M * (N + 1)));
      step();
      check_val("done_clear", 64'(done), 64'd0);
      repeat (5) step();
      check_val("no_extra_valid", 64'(y_valid), 64'd0);
   endtask

   initial begin
      set_all(32'h0000_0000, 32'h0000_0000);
      rst_n = 1'b0;
      step();
      step();
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_y_valid", 64'(y_valid), 64'd0);
      check_val("rst_y_data", 64'(y_data), 64'd0);
      check_val("rst_y_index", 64'(y_index), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      step();

      // Identity column: x = e0 * 1.0 gives y[r] = A(r,0) exactly
      set_pattern();
      for (int c = 0; c < N; c++) x_v[c] = 32'h0000_0000;
      x_v[0] = 32'h0001_0000;
      for (int r = 0; r < M; r++) exp_y[r] = a_m[r][0];
      do_run(-1, -1, -1, 1'b1);

      // All x = 1.0: row sums from the reference, with a stall on row 3 and a stray start
      for (int c = 0; c < N; c++) x_v[c] = 32'h0001_0000;
      for (int r = 0; r < M; r++) exp_y[r] = golden(r);
      do_run(3, 10, -1, 1'b0);

      // Positive saturation
      set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      for (int r = 0; r < M; r++) exp_y[r] = 32'h7FFF_FFFF;
      do_run(-1, -1, -1, 1'b0);

      // Negative saturation
      set_all(32'h8000_0000, 32'h7FFF_FFFF);
      for (int r = 0; r < M; r++) exp_y[r] = 32'h8000_0000;
      do_run(-1, -1, -1, 1'b0);

      // Truncation: -1.0 * 0.5 = -0.5
      set_all(32'h0000_0000, 32'h0000_0000);
      a_m[0][0] = 32'hFFFF_0000;
      x_v[0]    = 32'h0000_8000;
      for (int r = 0; r < M; r++) exp_y[r] = 32'h0000_0000;
      exp_y[0] = 32'hFFFF_8000;
      do_run(-1, -1, -1, 1'b0);

      // Truncation toward minus infinity: tiny negative product rounds to -1 LSB
      a_m[0][0] = 32'hFFFF_FFFF;
      x_v[0]    = 32'h0000_0001;
      exp_y[0]  = 32'hFFFF_FFFF;
      do_run(-1, -1, -1, 1'b0);

      // Reset during row 5 MAC, then a fresh run
      set_pattern();
      for (int c = 0; c < N; c++) x_v[c] = 32'h0000_0000;
      x_v[0] = 32'h0001_0000;
      for (int r = 0; r < M; r++) exp_y[r] = a_m[r][0];
      do_run(-1, -1, 5, 1'b0);
      step();
      do_run(-1, -1, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
